// File: rtl/pattern_rotator.sv
// Circular register file that rotates all entries one position every div+1 cycles while running.
// Entries are writable only when idle; every output is registered except wr_ready (a decode of the state register).
module pattern_rotator #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 16,
  parameter int DIV_W = 16,
  parameter logic [WIDTH*SIZE-1:0] INIT = '0,
  localparam int AW = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  dir,
  input  logic [DIV_W-1:0]      div,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH*SIZE-1:0] reg_out,
  output logic [AW-1:0]         head,
  output logic                  step_pulse
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    head_q, head_d;
  logic             step_q, step_d;
  logic [WIDTH-1:0] ent_q [SIZE];
  logic [WIDTH-1:0] ent_d [SIZE];
  logic             do_step;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    step_d  = 1'b0;
    do_step = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      ent_d[i] = ent_q[i];
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Out-of-range addresses match no entry, so the handshake completes harmlessly.
        if (wr_valid) begin
          for (int i = 0; i < SIZE; i++) begin
            if (wr_addr == AW'(i)) ent_d[i] = wr_data;
          end
        end
        if (run) state_d = RUN;
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= div) begin
          do_step = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
    endcase

    if (do_step) begin
      step_d = 1'b1;
      for (int i = 0; i < SIZE; i++) begin
        if (dir) ent_d[i] = ent_q[(i + 1) % SIZE];
        else     ent_d[i] = ent_q[(i + SIZE - 1) % SIZE];
      end
      // Explicit wrap keeps head correct when SIZE is not a power of two.
      if (!dir) head_d = (head_q == AW'(SIZE - 1)) ? '0 : head_q + AW'(1);
      else      head_d = (head_q == '0) ? AW'(SIZE - 1) : head_q - AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      head_q  <= '0;
      step_q  <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        ent_q[i] <= INIT[i*WIDTH +: WIDTH];
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      step_q  <= step_d;
      for (int i = 0; i < SIZE; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign wr_ready   = (state_q == IDLE);
  assign head       = head_q;
  assign step_pulse = step_q;

  for (genvar g = 0; g < SIZE; g++) begin : g_out
    assign reg_out[g*WIDTH +: WIDTH] = ent_q[g];
  end

endmodule

// File: tb/tb_pattern_rotator.sv
// Scoreboard bench: two rotators (SIZE=4 and SIZE=3) share stimulus; a list-based model predicts each cycle.
module tb_pattern_rotator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        dir = 1'b0;
  logic [3:0]  div = '0;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;

  logic        rdy4, rdy3, sp4, sp3;
  logic [1:0]  hd4, hd3;
  logic [31:0] ro4;
  logic [23:0] ro3;

  always #5 clk = ~clk;

  pattern_rotator #(.WIDTH(8), .SIZE(4), .DIV_W(4), .INIT(32'h44332211)) u4 (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .div(div),
    .wr_valid(wr_valid), .wr_ready(rdy4), .wr_addr(wr_addr), .wr_data(wr_data),
    .reg_out(ro4), .head(hd4), .step_pulse(sp4)
  );

  pattern_rotator #(.WIDTH(8), .SIZE(3), .DIV_W(4), .INIT(24'h332211)) u3 (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .div(div),
    .wr_valid(wr_valid), .wr_ready(rdy3), .wr_addr(wr_addr), .wr_data(wr_data),
    .reg_out(ro3), .head(hd3), .step_pulse(sp3)
  );

  typedef struct packed {
    logic [31:0] ro;
    logic [1:0]  hd;
    logic        sp;
    logic        rdy;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  exp_t e4, e3;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: entries as a plain list per instance, rotated by index arithmetic.
  logic [7:0] m_ent [2][4];
  int         m_n   [2] = '{4, 3};
  bit         m_on  [2];
  int         m_cnt [2];
  int         m_head[2];
  bit         m_sp  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset(input int k);
    logic [31:0] init;
    init = (k == 0) ? 32'h44332211 : 32'h00332211;
    for (int i = 0; i < 4; i++) m_ent[k][i] = (i < m_n[k]) ? init[i*8 +: 8] : 8'h00;
    m_on[k] = 0; m_cnt[k] = 0; m_head[k] = 0; m_sp[k] = 0;
  endtask

  task automatic model_edge(input int k);
    logic [7:0] tmp [4];
    int n;
    n = m_n[k];
    m_sp[k] = 0;
    if (rst) begin
      model_reset(k);
    end else if (!m_on[k]) begin
      if (wr_valid && int'(wr_addr) < n) m_ent[k][wr_addr] = wr_data;
      if (run) begin m_on[k] = 1; m_cnt[k] = 0; end
    end else if (!run) begin
      m_on[k] = 0; m_cnt[k] = 0;
    end else if (m_cnt[k] >= int'(div)) begin
      tmp = m_ent[k];
      for (int i = 0; i < n; i++) begin
        if (!dir) m_ent[k][(i + 1) % n]     = tmp[i];
        else      m_ent[k][(i + n - 1) % n] = tmp[i];
      end
      m_head[k] = dir ? (m_head[k] + n - 1) % n : (m_head[k] + 1) % n;
      m_cnt[k] = 0;
      m_sp[k]  = 1;
    end else begin
      m_cnt[k]++;
    end
  endtask

  function automatic exp_t snap(input int k);
    exp_t e;
    e = '0;
    for (int i = 0; i < m_n[k]; i++) e.ro[i*8 +: 8] = m_ent[k][i];
    e.hd  = 2'(m_head[k]);
    e.sp  = m_sp[k];
    e.rdy = !m_on[k];
    return e;
  endfunction

  // One clock: drive on the falling edge, predict, then return just after the rising edge.
  task automatic cyc(input bit r, input bit d, input logic [3:0] dv,
                     input bit wv, input logic [1:0] wa, input logic [7:0] wd);
    @(negedge clk);
    run = r; dir = d; div = dv; wr_valid = wv; wr_addr = wa; wr_data = wd;
    model_edge(0); model_edge(1);
    q4.push_back(snap(0));
    q3.push_back(snap(1));
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    model_reset(0); model_reset(1);
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      chk("s4.reg_out", ro4, e4.ro);
      chk("s4.head", 32'(hd4), 32'(e4.hd));
      chk("s4.step_pulse", 32'(sp4), 32'(e4.sp));
      chk("s4.wr_ready", 32'(rdy4), 32'(e4.rdy));
    end
    if (q3.size() > 0) begin
      e3 = q3.pop_front();
      chk("s3.reg_out", 32'(ro3), e3.ro);
      chk("s3.head", 32'(hd3), 32'(e3.hd));
      chk("s3.step_pulse", 32'(sp3), 32'(e3.sp));
      chk("s3.wr_ready", 32'(rdy3), 32'(e3.rdy));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit r, d, wv;
    logic [3:0] dv;
    model_reset(0); model_reset(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    repeat (5) cyc(0, 0, 0, 0, 0, 0);
    chk("reset.reg_out", ro4, 32'h44332211);
    chk("reset.head", 32'(hd4), 32'd0);
    chk("reset.wr_ready", 32'(rdy4), 32'd1);
    chk("reset.step_pulse", 32'(sp4), 32'd0);

    // div=2, dir=0: enter on the first edge, step on every third edge after.
    for (int i = 0; i < 13; i++) begin
      cyc(1, 0, 2, 0, 0, 0);
      if (i == 3) begin
        chk("first_step.reg_out", ro4, 32'h33221144);
        chk("first_step.head", 32'(hd4), 32'd1);
        chk("first_step.pulse", 32'(sp4), 32'd1);
        chk("first_step.ready", 32'(rdy4), 32'd0);
      end
    end
    chk("four_steps.reg_out", ro4, 32'h44332211);
    chk("four_steps.head", 32'(hd4), 32'd0);
    cyc(0, 0, 2, 0, 0, 0);
    cyc(0, 0, 2, 1, 2, 8'hAA);
    chk("idle_write.reg_out", ro4, 32'h44AA2211);
    cyc(1, 0, 3, 1, 1, 8'h55);
    cyc(1, 0, 3, 1, 0, 8'h99);
    chk("run_write_blocked", 32'(ro4[7:0]), 32'h11);
    cyc(0, 0, 0, 0, 0, 0);

    // Async reset landing between edges mid-run with cnt=1.
    pulse_reset();
    cyc(1, 0, 2, 0, 0, 0);
    cyc(1, 0, 2, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst.reg_out", ro4, 32'h44332211);
    chk("async_rst.head", 32'(hd4), 32'd0);
    chk("async_rst.wr_ready", 32'(rdy4), 32'd1);
    chk("async_rst.step_pulse", 32'(sp4), 32'd0);
    model_reset(0); model_reset(1);
    cyc(0, 0, 2, 0, 0, 0);
    rst = 1'b0;
    repeat (4) cyc(0, 0, 2, 0, 0, 0);

    // div=0, dir=1: rotate every cycle backwards, head wraps 0->3.
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("back_step.reg_out", ro4, 32'h11443322);
    chk("back_step.head", 32'(hd4), 32'd3);
    repeat (5) cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // SIZE=3 wrap and out-of-range write.
    pulse_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("s3_step.reg_out", 32'(ro3), 32'h00221133);
    chk("s3_step.head1", 32'(hd3), 32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("s3_step.head2", 32'(hd3), 32'd2);
    cyc(1, 0, 0, 0, 0, 0);
    chk("s3_step.head0", 32'(hd3), 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 3, 8'hEE);
    chk("s3_oob_write.reg_out", 32'(ro3), 32'h00332211);
    chk("s3_oob_write.ready", 32'(rdy3), 32'd1);

    // Randomized phase with mid-run div/dir changes and sporadic writes.
    r = 0; d = 0; dv = 2;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) r = ~r;
      if ($urandom_range(0, 5) == 0) d = ~d;
      if ($urandom_range(0, 4) == 0) dv = 4'($urandom_range(0, 3));
      wv = ($urandom_range(0, 1) == 1);
      cyc(r, d, dv, wv, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    cyc(0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #3;
    chk("drain.q4", 32'(q4.size()), 32'd0);
    chk("drain.q3", 32'(q3.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
